loadable_counter_n: RTL

Parametrised successor to the 8-bit latch/decrement/halve counter used in the timing datapath. It adds:
- configurable width and step size
- increment
- saturate or wrap arithmetic
- auto-reload from a stored reload value
- a sticky zero flag with explicit clear, plus single-cycle terminal and overflow events

It feeds interval timers and pacing logic on the single system clock.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_next_calc.sv | 64 ++++++
 rtl/loadable_counter_n.sv | 90 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the loadable counter family.
package counter_pkg;

  localparam int unsigned STEP_MAX_W = 32;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_LOAD,
    OP_DEC,
    OP_INC,
    OP_DIV,
    OP_HOLD
  } op_e;

  // A zero step is promoted to one so inc/dec always make progress.
  function automatic logic [STEP_MAX_W-1:0] effective_step(input logic [STEP_MAX_W-1:0] step);
    return (step == '0) ? STEP_MAX_W'(1) : step;
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation for inc/dec/div with terminal and overflow detection.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] reload,
  input  logic             reload_en,
  output logic [WIDTH-1:0] next_count_c,
  output logic             term_c,
  output logic             ovf_c
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [EXT_W-1:0] diff_c;
  logic [EXT_W-1:0] sum_c;
  logic             dec_term_c;

  assign diff_c = {1'b0, count} - {1'b0, s};
  assign sum_c  = {1'b0, count} + {1'b0, s};

  // Borrow out or an exact hit on zero both count as reaching terminal.
  assign dec_term_c = diff_c[WIDTH] | (diff_c[WIDTH-1:0] == '0);

  always_comb begin
    next_count_c = count;
    term_c       = 1'b0;
    ovf_c        = 1'b0;
    case (op)
      OP_DEC: begin
        term_c = dec_term_c;
        if (!dec_term_c) begin
          next_count_c = diff_c[WIDTH-1:0];
        end else if (reload_en) begin
          next_count_c = reload;
        end else if (SATURATE) begin
          next_count_c = '0;
        end else begin
          next_count_c = diff_c[WIDTH-1:0];
        end
      end
      OP_INC: begin
        ovf_c = sum_c[WIDTH];
        if (sum_c[WIDTH] && SATURATE) begin
          next_count_c = '1;
        end else begin
          next_count_c = sum_c[WIDTH-1:0];
        end
      end
      OP_DIV: begin
        next_count_c = count >> 1;
      end
      default: begin
        next_count_c = count;
      end
    endcase
  end

endmodule

// File: rtl/loadable_counter_n.sv
// Parametrised loadable up/down/halve counter with auto-reload, sticky zero flag and event pulses.
module loadable_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_sink_reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              latch,
  input  logic              dec,
  input  logic              inc,
  input  logic              div,
  input  logic [STEP_W-1:0] step,
  input  logic              reload_en,
  input  logic              clr_zero,
  output logic [WIDTH-1:0]  count,
  output logic              zero,
  output logic              term_pulse,
  output logic              ovf_pulse
);

  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] s_c;
  logic [WIDTH-1:0] next_count_c;
  logic             term_c;
  logic             ovf_c;
  op_e              op_c;

  assign s_c = WIDTH'(effective_step(STEP_MAX_W'(step)));

  // Priority decode: latch > inc/dec (conflict holds) > div > idle.
  always_comb begin
    op_c = OP_IDLE;
    if (latch) begin
      op_c = OP_LOAD;
    end else if (inc && dec) begin
      op_c = OP_HOLD;
    end else if (dec) begin
      op_c = OP_DEC;
    end else if (inc) begin
      op_c = OP_INC;
    end else if (div) begin
      op_c = OP_DIV;
    end
  end

  counter_next_calc #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next_calc (
    .op           (op_c),
    .count        (count),
    .s            (s_c),
    .reload       (reload_q),
    .reload_en    (reload_en),
    .next_count_c (next_count_c),
    .term_c       (term_c),
    .ovf_c        (ovf_c)
  );

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      count      <= '0;
      reload_q   <= '0;
      zero       <= 1'b0;
      term_pulse <= 1'b0;
      ovf_pulse  <= 1'b0;
    end else if (op_c == OP_LOAD) begin
      count      <= in;
      reload_q   <= in;
      zero       <= 1'b0;
      term_pulse <= 1'b0;
      ovf_pulse  <= 1'b0;
    end else begin
      count      <= next_count_c;
      term_pulse <= term_c;
      ovf_pulse  <= ovf_c;
      // A terminal event wins over a simultaneous clear.
      if (term_c) begin
        zero <= 1'b1;
      end else if (clr_zero) begin
        zero <= 1'b0;
      end
    end
  end

endmodule
